// File: rtl/obuf_reader_if.sv
// Read-port and result-stream bundle for the output-buffer reader.
// master = obuf_reader side; slave = column RAMs plus result consumer.
interface obuf_reader_if #(
    parameter int unsigned ARRAY_M      = 16,
    parameter int unsigned PE_OUT_WIDTH = 32,
    parameter int unsigned RAM_SIZE     = 1024,
    parameter int unsigned ADDR_WIDTH   = $clog2(RAM_SIZE)
);
    logic                        o_rd_en;
    logic [$clog2(ARRAY_M)-1:0]  o_ram_idx;
    logic [ADDR_WIDTH-1:0]       o_read_addr;
    logic [PE_OUT_WIDTH-1:0]     o_rd_data;
    logic                        m_valid;
    logic                        m_ready;
    logic [PE_OUT_WIDTH-1:0]     m_data;
    logic                        m_last;

    modport master (
        output o_rd_en, o_ram_idx, o_read_addr,
        input  o_rd_data,
        output m_valid, m_data, m_last,
        input  m_ready
    );

    modport slave (
        input  o_rd_en, o_ram_idx, o_read_addr,
        output o_rd_data,
        input  m_valid, m_data, m_last,
        output m_ready
    );
endinterface

// File: rtl/obuf_reader.sv
// Walks a result tile row-major across the column RAMs and streams each word out
// through a 2-entry FIFO that absorbs the one-cycle RAM read latency.
module obuf_reader #(
    parameter int unsigned ARRAY_M      = 16,
    parameter int unsigned ARRAY_N      = 16,
    parameter int unsigned PE_OUT_WIDTH = 32,
    parameter int unsigned RAM_SIZE     = 1024,
    parameter int unsigned ADDR_WIDTH   = $clog2(RAM_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [$clog2(ARRAY_N):0]   num_rows,
    input  logic [$clog2(ARRAY_M):0]   num_cols,
    output logic                       busy,
    output logic                       done,
    obuf_reader_if.master              bus
);
    localparam int unsigned RowW = $clog2(ARRAY_N) + 1;
    localparam int unsigned ColW = $clog2(ARRAY_M) + 1;
    localparam int unsigned IdxW = $clog2(ARRAY_M);

    typedef enum logic [1:0] {StIdle, StRead, StFlush, StDone} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [RowW-1:0]         rows_q, rows_d, r_q, r_d;
    logic [ColW-1:0]         cols_q, cols_d, c_q, c_d;
    logic                    inflight_q, inflight_d;
    logic                    infl_last_q, infl_last_d;
    logic [PE_OUT_WIDTH-1:0] fifo_data_q [2];
    logic [PE_OUT_WIDTH-1:0] fifo_data_d [2];
    logic [1:0]              fifo_last_q, fifo_last_d;
    logic                    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]              cnt_q, cnt_d;

    logic       pop, rd_fire, last_elem;
    logic [2:0] credit;

    always_comb begin
        pop       = (cnt_q != 2'd0) & bus.m_ready;
        // Occupancy after this cycle's returns and pops; a new read needs a free slot.
        credit    = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_fire   = (state_q == StRead) && (credit < 3'd2);
        last_elem = (r_q == rows_q - RowW'(1)) && (c_q == cols_q - ColW'(1));

        state_d     = state_q;
        base_d      = base_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        r_d         = r_q;
        c_d         = c_q;
        inflight_d  = rd_fire;
        infl_last_d = rd_fire & last_elem;
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q + {1'b0, inflight_q} - {1'b0, pop};

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (num_rows == '0 || num_cols == '0) begin
                        state_d = StDone;
                    end else begin
                        base_d  = base_addr;
                        rows_d  = (num_rows > RowW'(ARRAY_N)) ? RowW'(ARRAY_N) : num_rows;
                        cols_d  = (num_cols > ColW'(ARRAY_M)) ? ColW'(ARRAY_M) : num_cols;
                        r_d     = '0;
                        c_d     = '0;
                        state_d = StRead;
                    end
                end
            end
            StRead: begin
                if (rd_fire) begin
                    if (c_q == cols_q - ColW'(1)) begin
                        c_d = '0;
                        r_d = r_q + RowW'(1);
                    end else begin
                        c_d = c_q + ColW'(1);
                    end
                    if (last_elem) state_d = StFlush;
                end
            end
            StFlush: begin
                // Leave once the FIFO drains this cycle so done lands right after the last pop.
                if (!inflight_q && cnt_q == {1'b0, pop}) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (inflight_q) begin
            fifo_data_d[wr_ptr_q] = bus.o_rd_data;
            fifo_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            base_q         <= '0;
            rows_q         <= '0;
            cols_q         <= '0;
            r_q            <= '0;
            c_q            <= '0;
            inflight_q     <= 1'b0;
            infl_last_q    <= 1'b0;
            fifo_data_q[0] <= '0;
            fifo_data_q[1] <= '0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= 1'b0;
            rd_ptr_q       <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            rows_q         <= rows_d;
            cols_q         <= cols_d;
            r_q            <= r_d;
            c_q            <= c_d;
            inflight_q     <= inflight_d;
            infl_last_q    <= infl_last_d;
            fifo_data_q[0] <= fifo_data_d[0];
            fifo_data_q[1] <= fifo_data_d[1];
            fifo_last_q    <= fifo_last_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        busy            = (state_q == StRead) || (state_q == StFlush);
        done            = (state_q == StDone);
        bus.o_rd_en     = rd_fire;
        bus.o_ram_idx   = c_q[IdxW-1:0];
        bus.o_read_addr = base_q + ADDR_WIDTH'(r_q);
        bus.m_valid     = (cnt_q != 2'd0);
        bus.m_data      = bus.m_valid ? fifo_data_q[rd_ptr_q] : '0;
        bus.m_last      = bus.m_valid & fifo_last_q[rd_ptr_q];
    end
endmodule

// File: doc/obuf_reader.md
# obuf_reader

Read-side engine for the systolic output buffer. After an OS drain has written a num_rows × num_cols result tile into the ARRAY_M column RAMs, this block walks the tile in row-major order. It issues one read per element, absorbs the one-cycle RAM read latency, and streams the 32-bit results to the BRAM/host side over a valid/ready handshake. It sits between the output-buffer read port (o_ram_idx, o_read_addr, read data) and the result write-back path, replacing manual per-address readback.

## Interface
- ARRAY_M, 16, number of output column RAMs (tile width limit)
- ARRAY_N, 16, tile height limit
- PE_OUT_WIDTH, 32, result word width
- RAM_SIZE, 1024, depth of each column RAM
- ADDR_WIDTH, $clog2(RAM_SIZE), RAM address width
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  address of tile row 0, sampled with start
- num_rows  in  $clog2(ARRAY_N)+1  tile rows, sampled with start
- num_cols  in  $clog2(ARRAY_M)+1  tile columns, sampled with start
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse on completion
- o_rd_en  out  1  RAM read strobe
- o_ram_idx  out  $clog2(ARRAY_M)  column RAM select (= column c)
- o_read_addr  out  ADDR_WIDTH  base_addr + r, modulo RAM_SIZE
- o_rd_data  in  PE_OUT_WIDTH  RAM data, valid one cycle after o_rd_en
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  PE_OUT_WIDTH  element (r,c)
- m_last  out  1  high with the final element of the tile

## Operation
- States: IDLE, READ, FLUSH, DONE.
- IDLE, start=1, both dims nonzero:
  - latch base_addr and dims; values above ARRAY_N/ARRAY_M saturate to the limit;
  - clear the r/c counters; go to READ.
- IDLE, start=1, either dim zero: go to DONE directly; no reads, no output words.
- READ:
  - each cycle a read is allowed, drive o_rd_en=1, o_ram_idx=c, o_read_addr=base+r;
  - advance c; when c wraps at num_cols-1, reset c to 0 and increment r;
  - after issuing (num_rows-1, num_cols-1), go to FLUSH.
- A read is allowed when fifo_count + inflight − pop < 2, where:
  - inflight is 0 or 1;
  - fifo_count is the occupancy of a 2-entry output FIFO (0..2);
  - pop = m_valid & m_ready.
- This credit rule guarantees returning data always has a FIFO slot. Data is never dropped and no read is issued twice.
- o_rd_data is written into the FIFO in the cycle after o_rd_en.
- m_data and m_valid come from the FIFO head. m_last is tagged on the final element's entry.
- FLUSH: wait until inflight=0 and the FIFO is empty, then go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. busy drops in the same cycle done is asserted.
- start while busy/not IDLE: ignored.
- Address wrap: base_addr + r ≥ RAM_SIZE wraps modulo RAM_SIZE.
- m_data and m_last must hold stable while m_valid=1 and m_ready=0.

## Timing
- Reset (reset_n=0, asynchronous, any state):
  - state IDLE; counters, FIFO and inflight cleared;
  - busy, done, o_rd_en, m_valid, m_last = 0;
  - o_ram_idx, o_read_addr, m_data = 0.
- Reset mid-tile abandons the tile; no done pulse.
- Start latency, with start high in cycle 0: first o_rd_en in cycle 1, first m_valid in cycle 3.
- Throughput: 1 word/cycle while m_ready=1.
- With m_ready held 1: R×C tile has its last handshake in cycle R·C+2; done pulses in cycle R·C+3.
- The zero-dimension case pulses done in cycle 1.
- o_rd_en is never high while busy=0.

## Test plan
- Preload RAM c, addr r with 100·r+c. Run base=0, rows=3, cols=2, m_ready=1:
  - output sequence 0,1,100,101,200,201;
  - m_last only on 201; done in cycle 9.
- Same tile with m_ready toggling 1,0,0,1,…:
  - identical sequence, no duplicates or drops;
  - o_rd_en never high when the FIFO credit would be exceeded;
  - m_data stable while stalled.
- base=1023, rows=2, cols=1 → reads at addr 1023 then 0; output equals the preloaded RAM0[1023], RAM0[0].
- rows=0, cols=5 → done pulse in cycle 1; no o_rd_en; no m_valid.
- rows=16, cols=16 with m_ready=1 → 256 words in order; m_last on word 255.
  - A second start pulsed mid-tile is ignored.
- Assert reset_n low mid-tile after 5 words:
  - all outputs return to 0 immediately;
  - a fresh start then produces the full tile from element (0,0).
